vending_ctrl: RTL and testbench

- Vending-machine control FSM that accepts coins, accumulates credit, serves item selections, and pays out change through a handshake.
- Drives the 7-bit `credit` value consumed by the two-digit seven-segment display stage directly downstream.
- Credit is capped at MAX_CREDIT = 19 so the display range 00–19 is never exceeded.

---
 rtl/vending_ctrl.sv | 153 +++++++++++++++
 tb/tb_vending_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/vending_ctrl.sv
// Vending controller: coin credit accumulation, item dispense and change payout handshake.
// All outputs registered (1-cycle response); change_valid holds until change_ack is seen.
module vending_ctrl #(
  parameter int MAX_CREDIT = 19,
  parameter int PRICE0     = 3,
  parameter int PRICE1     = 5,
  parameter int PRICE2     = 8,
  parameter int PRICE3     = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_valid,
  input  logic [1:0] coin_value,
  input  logic       sel_valid,
  input  logic [1:0] sel_item,
  input  logic       cancel,
  input  logic       change_ack,
  output logic [6:0] credit,
  output logic       coin_reject,
  output logic       insufficient,
  output logic       dispense,
  output logic [1:0] item_out,
  output logic       change_valid,
  output logic [4:0] change_amount
);

  typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, CHANGE} state_t;

  localparam logic [7:0] MaxC = 8'(MAX_CREDIT);

  state_t      state_q, state_d;
  logic [6:0]  credit_q, credit_d;
  logic        coin_reject_q, coin_reject_d;
  logic        insufficient_q, insufficient_d;
  logic        dispense_q, dispense_d;
  logic [1:0]  item_q, item_d;
  logic        change_valid_q, change_valid_d;
  logic [4:0]  change_amount_q, change_amount_d;

  logic [7:0]  price;
  logic [7:0]  coin_amt;
  logic [7:0]  sum;

  always_comb begin
    price = 8'(PRICE0);
    case (sel_item)
      2'd0:    price = 8'(PRICE0);
      2'd1:    price = 8'(PRICE1);
      2'd2:    price = 8'(PRICE2);
      default: price = 8'(PRICE3);
    endcase
    coin_amt = 8'd0;
    case (coin_value)
      2'b00:   coin_amt = 8'd1;
      2'b01:   coin_amt = 8'd2;
      2'b10:   coin_amt = 8'd5;
      default: coin_amt = 8'd0;
    endcase
    // Evaluated at 8 bits so an over-cap sum cannot wrap below the ceiling.
    sum = {1'b0, credit_q} + coin_amt;
  end

  always_comb begin
    state_d         = state_q;
    credit_d        = credit_q;
    coin_reject_d   = 1'b0;
    insufficient_d  = 1'b0;
    dispense_d      = 1'b0;
    item_d          = item_q;
    change_valid_d  = change_valid_q;
    change_amount_d = change_amount_q;

    case (state_q)
      IDLE, COLLECT: begin
        // Priority: cancel > selection > coin; a coin that loses is refused.
        if (cancel && state_q == COLLECT) begin
          state_d         = CHANGE;
          change_valid_d  = 1'b1;
          change_amount_d = credit_q[4:0];
          coin_reject_d   = coin_valid;
        end else if (sel_valid) begin
          coin_reject_d = coin_valid;
          if (state_q == COLLECT && {1'b0, credit_q} >= price) begin
            state_d    = DISPENSE;
            credit_d   = credit_q - price[6:0];
            dispense_d = 1'b1;
            item_d     = sel_item;
          end else begin
            insufficient_d = 1'b1;
          end
        end else if (coin_valid) begin
          if (coin_value == 2'b11 || sum > MaxC) begin
            coin_reject_d = 1'b1;
          end else begin
            credit_d = sum[6:0];
            state_d  = COLLECT;
          end
        end
      end
      DISPENSE: begin
        coin_reject_d = coin_valid;
        if (credit_q != 7'd0) begin
          state_d         = CHANGE;
          change_valid_d  = 1'b1;
          change_amount_d = credit_q[4:0];
        end else begin
          state_d = IDLE;
        end
      end
      CHANGE: begin
        coin_reject_d = coin_valid;
        if (change_ack) begin
          state_d         = IDLE;
          credit_d        = 7'd0;
          change_valid_d  = 1'b0;
          change_amount_d = 5'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      credit_q        <= 7'd0;
      coin_reject_q   <= 1'b0;
      insufficient_q  <= 1'b0;
      dispense_q      <= 1'b0;
      item_q          <= 2'd0;
      change_valid_q  <= 1'b0;
      change_amount_q <= 5'd0;
    end else begin
      state_q         <= state_d;
      credit_q        <= credit_d;
      coin_reject_q   <= coin_reject_d;
      insufficient_q  <= insufficient_d;
      dispense_q      <= dispense_d;
      item_q          <= item_d;
      change_valid_q  <= change_valid_d;
      change_amount_q <= change_amount_d;
    end
  end

  assign credit        = credit_q;
  assign coin_reject   = coin_reject_q;
  assign insufficient  = insufficient_q;
  assign dispense      = dispense_q;
  assign item_out      = item_q;
  assign change_valid  = change_valid_q;
  assign change_amount = change_amount_q;

endmodule

// File: tb/tb_vending_ctrl.sv
// Scoreboard bench for vending_ctrl: driver pushes model predictions, monitor checks each cycle.
module tb_vending_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       coin_valid, sel_valid, cancel, change_ack;
  logic [1:0] coin_value, sel_item;
  logic [6:0] credit;
  logic       coin_reject, insufficient, dispense, change_valid;
  logic [1:0] item_out;
  logic [4:0] change_amount;

  vending_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .coin_valid(coin_valid), .coin_value(coin_value),
    .sel_valid(sel_valid), .sel_item(sel_item),
    .cancel(cancel), .change_ack(change_ack),
    .credit(credit), .coin_reject(coin_reject), .insufficient(insufficient),
    .dispense(dispense), .item_out(item_out),
    .change_valid(change_valid), .change_amount(change_amount)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   credit;
    logic rej;
    logic ins;
    logic disp;
    logic [1:0] item;
    logic cv;
    int   amt;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: credit as an integer plus "item just released" and "paying out" flags.
  int   prices[4]    = '{3, 5, 8, 12};
  int   coin_vals[4] = '{1, 2, 5, 0};
  int   m_credit;
  bit   m_released;
  bit   m_paying;
  int   m_amt;
  logic [1:0] m_item;

  task automatic model_reset();
    m_credit = 0; m_released = 0; m_paying = 0; m_amt = 0; m_item = 2'd0;
  endtask

  function automatic exp_t model_step(input logic cv, input logic [1:0] cc, input logic sv,
                                      input logic [1:0] si, input logic cn, input logic ak);
    exp_t e;
    e.rej = 1'b0; e.ins = 1'b0; e.disp = 1'b0;
    if (m_released) begin
      m_released = 0;
      e.rej = cv;
      if (m_credit > 0) begin
        m_paying = 1; m_amt = m_credit;
      end
    end else if (m_paying) begin
      e.rej = cv;
      if (ak) begin
        m_paying = 0; m_credit = 0;
      end
    end else if (cn && m_credit > 0) begin
      m_paying = 1; m_amt = m_credit; e.rej = cv;
    end else if (sv) begin
      e.rej = cv;
      if (m_credit > 0 && m_credit >= prices[si]) begin
        m_credit -= prices[si]; m_released = 1; m_item = si; e.disp = 1'b1;
      end else begin
        e.ins = 1'b1;
      end
    end else if (cv) begin
      if (cc == 2'b11 || m_credit + coin_vals[cc] > 19) e.rej = 1'b1;
      else m_credit += coin_vals[cc];
    end
    e.credit = m_credit;
    e.item   = m_item;
    e.cv     = m_paying;
    e.amt    = m_amt;
    return e;
  endfunction

  task automatic step(input logic cv, input logic [1:0] cc, input logic sv,
                      input logic [1:0] si, input logic cn, input logic ak);
    @(negedge clk);
    coin_valid = cv; coin_value = cc; sel_valid = sv; sel_item = si;
    cancel = cn; change_ack = ak;
    exp_q.push_back(model_step(cv, cc, sv, si, cn, ak));
  endtask

  task automatic idle();
    step(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic coin(input logic [1:0] cc);
    step(1'b1, cc, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic check_zero(input string name);
    n_tests++;
    if (credit !== 7'd0 || coin_reject !== 1'b0 || insufficient !== 1'b0 || dispense !== 1'b0 ||
        item_out !== 2'd0 || change_valid !== 1'b0 || change_amount !== 5'd0) begin
      n_fail++;
      $display("FAIL %s: credit=%0d rej=%b ins=%b disp=%b item=%0d cv=%b amt=%0d, required all zero",
               name, credit, coin_reject, insufficient, dispense, item_out, change_valid, change_amount);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (credit !== 7'(e.credit) || coin_reject !== e.rej || insufficient !== e.ins ||
            dispense !== e.disp || item_out !== e.item || change_valid !== e.cv ||
            (e.cv && change_amount !== 5'(e.amt))) begin
          n_fail++;
          $display("FAIL outputs @%0t: got credit=%0d rej=%b ins=%b disp=%b item=%0d cv=%b amt=%0d; want credit=%0d rej=%b ins=%b disp=%b item=%0d cv=%b amt=%0d",
                   $time, credit, coin_reject, insufficient, dispense, item_out, change_valid, change_amount,
                   e.credit, e.rej, e.ins, e.disp, e.item, e.cv, e.amt);
        end
      end
    end
  end

  initial begin : driver
    rst_n = 1'b0;
    coin_valid = 1'b0; coin_value = 2'd0; sel_valid = 1'b0; sel_item = 2'd0;
    cancel = 1'b0; change_ack = 1'b0;
    model_reset();
    #13;
    check_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    // Coins 5, 5, 2 -> 12, then buy item 1 and collect 7 change after a delayed ack.
    coin(2'b10); idle(); coin(2'b10); idle(); coin(2'b01); idle();
    step(1'b0, 2'd0, 1'b1, 2'd1, 1'b0, 1'b0);
    idle(); idle(); idle(); idle();
    step(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1);
    idle();

    // Ceiling: 18 + 5 refused, +1 reaches 19, invalid code refused.
    coin(2'b10); coin(2'b10); coin(2'b10); coin(2'b01); coin(2'b00);
    coin(2'b10); coin(2'b00); coin(2'b11);
    step(1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0);
    step(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1);

    // Credit 4, item 2 refused, then cancel refunds 4.
    coin(2'b01); coin(2'b01);
    step(1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 1'b0);
    step(1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0);
    idle();
    step(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1);

    // Simultaneous cancel + select + coin at credit 10.
    coin(2'b10); coin(2'b10);
    step(1'b1, 2'b00, 1'b1, 2'd0, 1'b1, 1'b0);
    idle();
    step(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1);

    // Exact price: no change, straight back to idle.
    coin(2'b01); coin(2'b00);
    step(1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0);
    idle(); idle();

    // Async reset while paying out.
    coin(2'b00);
    step(1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("reset_mid_change");
    exp_q.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 45), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 99) < 12), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 99) < 4),  ($urandom_range(0, 99) < 35));
    end
    idle();
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d predictions left unchecked, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
